// File: rtl/afifo_rd_stream_pkg.sv
// Shared types for the async-FIFO read-side drain engine.
// Holds the skid buffer state encoding and the handshake counter width.
package afifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  localparam int POP_CNT_W = 16;

endpackage

// File: rtl/afifo_rd_stream_skid_buf2.sv
// Two-entry valid/ready skid buffer with registered outputs and occupancy.
// The head register drives m_data directly; the skid register only fills under backpressure.
module skid_buf2
  import afifo_rd_stream_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic [1:0]   occ,
  output logic         full
);

  skid_state_t  state_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] skid_reg;
  logic         valid_reg;
  logic [1:0]   occ_reg;
  logic         take;

  assign take    = valid_reg & m_ready;
  assign m_valid = valid_reg;
  assign m_data  = head_reg;
  assign occ     = occ_reg;
  // full comes straight from the state register so the pop path never sees m_ready
  assign full    = (state_reg == ST_TWO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
      valid_reg <= 1'b0;
      occ_reg   <= 2'd0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (push) begin
            head_reg  <= din;
            state_reg <= ST_ONE;
            valid_reg <= 1'b1;
            occ_reg   <= 2'd1;
          end
        end
        ST_ONE: begin
          if (push && !take) begin
            skid_reg  <= din;
            state_reg <= ST_TWO;
            occ_reg   <= 2'd2;
          end else if (!push && take) begin
            state_reg <= ST_EMPTY;
            valid_reg <= 1'b0;
            occ_reg   <= 2'd0;
          end else if (push && take) begin
            head_reg <= din;
          end
        end
        ST_TWO: begin
          if (take) begin
            head_reg  <= skid_reg;
            state_reg <= ST_ONE;
            occ_reg   <= 2'd1;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
          valid_reg <= 1'b0;
          occ_reg   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/afifo_rd_stream.sv
// Read-domain drain engine: pops the async FIFO and re-presents entries on a
// registered valid/ready stream, pacing pops to the FIFO read latency.
module afifo_rd_stream
  import afifo_rd_stream_pkg::*;
#(
  parameter int AFIFODW = 32,
  parameter int RDLAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rqempty,
  input  logic [AFIFODW-1:0]   rdata,
  output logic                 rnext,
  output logic                 m_valid,
  output logic [AFIFODW-1:0]   m_data,
  input  logic                 m_ready,
  output logic [1:0]           occ,
  output logic [POP_CNT_W-1:0] pop_cnt
);

  logic                 full;
  logic                 hold;
  logic                 take;
  logic [POP_CNT_W-1:0] pop_cnt_reg;

  assign rnext   = rst_n & en & ~rqempty & ~full & ~hold;
  assign take    = m_valid & m_ready;
  assign pop_cnt = pop_cnt_reg;

  generate
    if (RDLAT != 0) begin : g_hold
      // A registered read RAM only shows the new pointer's entry one cycle after a pop
      logic hold_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) hold_reg <= 1'b0;
        else        hold_reg <= rnext;
      end
      assign hold = hold_reg;
    end else begin : g_no_hold
      assign hold = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)    pop_cnt_reg <= '0;
    else if (take) pop_cnt_reg <= pop_cnt_reg + 1'b1;
  end

  skid_buf2 #(.W(AFIFODW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rnext),
    .din     (rdata),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .occ     (occ),
    .full    (full)
  );

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Scoreboard bench: lane 0 uses a combinational-read FIFO model (RDLAT=0),
// lane 1 a registered-read FIFO model (RDLAT=1).
module tb_afifo_rd_stream;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred where none was expected", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- lane 0: RDLAT=0 ----------------
  logic          rst0 = 1'b0, en0 = 1'b0, m_ready0 = 1'b0, wr_en0 = 1'b0;
  logic [DW-1:0] wr_data0 = '0;
  logic          rqempty0, rnext0, m_valid0;
  logic [DW-1:0] rdata0, m_data0;
  logic [1:0]    occ0;
  logic [15:0]   pop_cnt0;
  logic [DW-1:0] mem0 [4];
  logic [2:0]    wptr0 = '0, wptr0_d = '0, rptr0 = '0;
  logic [DW-1:0] exp0[$], fly0[$];
  int            rn_cnt0 = 0;

  assign rqempty0 = (wptr0_d == rptr0);
  assign rdata0   = mem0[rptr0[1:0]];

  always @(posedge clk) begin
    if (wr_en0) begin
      mem0[wptr0[1:0]] <= wr_data0;
      wptr0 <= wptr0 + 3'd1;
      exp0.push_back(wr_data0);
    end
    wptr0_d <= wptr0;
    if (rnext0) rptr0 <= rptr0 + 3'd1;
  end

  afifo_rd_stream #(.AFIFODW(DW), .RDLAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst0), .en(en0), .rqempty(rqempty0), .rdata(rdata0),
    .rnext(rnext0), .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready0),
    .occ(occ0), .pop_cnt(pop_cnt0)
  );

  // ---------------- lane 1: RDLAT=1 ----------------
  logic          rst1 = 1'b0, en1 = 1'b0, m_ready1 = 1'b0, wr_en1 = 1'b0;
  logic [DW-1:0] wr_data1 = '0;
  logic          rqempty1, rnext1, m_valid1;
  logic [DW-1:0] rdata1, m_data1;
  logic [1:0]    occ1;
  logic [15:0]   pop_cnt1;
  logic [DW-1:0] mem1 [4];
  logic [2:0]    wptr1 = '0, wptr1_d = '0, rptr1 = '0;
  logic [DW-1:0] exp1[$], fly1[$];
  int            rn_cnt1 = 0;

  assign rqempty1 = (wptr1_d == rptr1);

  always @(posedge clk) begin
    if (wr_en1) begin
      mem1[wptr1[1:0]] <= wr_data1;
      wptr1 <= wptr1 + 3'd1;
      exp1.push_back(wr_data1);
    end
    wptr1_d <= wptr1;
    rdata1  <= mem1[rptr1[1:0]];
    if (rnext1) rptr1 <= rptr1 + 3'd1;
  end

  afifo_rd_stream #(.AFIFODW(DW), .RDLAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst1), .en(en1), .rqempty(rqempty1), .rdata(rdata1),
    .rnext(rnext1), .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready1),
    .occ(occ1), .pop_cnt(pop_cnt1)
  );

  // ---------------- monitors ----------------
  logic          hold0_prev = 1'b0, hold1_prev = 1'b0, rn1_prev = 1'b0;
  logic [DW-1:0] data0_prev = '0, data1_prev = '0;

  always @(negedge clk) begin
    if (!rst0) begin
      fly0.delete();
      hold0_prev = 1'b0;
      check("rnext0_in_reset", {31'b0, rnext0}, 32'd0);
    end else begin
      if (hold0_prev) begin
        check("stall0_valid", {31'b0, m_valid0}, 32'd1);
        check("stall0_data", m_data0, data0_prev);
      end
      if (m_valid0 && m_ready0) begin
        if (fly0.size() == 0) flag("take0_without_pop");
        else check("m_data0", m_data0, fly0.pop_front());
      end
      if (rnext0) begin
        rn_cnt0++;
        if (exp0.size() == 0) flag("pop0_from_empty");
        else fly0.push_back(exp0.pop_front());
      end
      hold0_prev = m_valid0 & ~m_ready0;
      data0_prev = m_data0;
    end
  end

  always @(negedge clk) begin
    if (!rst1) begin
      fly1.delete();
      hold1_prev = 1'b0;
      rn1_prev   = 1'b0;
      check("rnext1_in_reset", {31'b0, rnext1}, 32'd0);
    end else begin
      if (hold1_prev) check("stall1_data", m_data1, data1_prev);
      if (m_valid1 && m_ready1) begin
        if (fly1.size() == 0) flag("take1_without_pop");
        else check("m_data1", m_data1, fly1.pop_front());
      end
      if (rnext1) begin
        rn_cnt1++;
        check("rnext1_spacing", {31'b0, rn1_prev}, 32'd0);
        if (exp1.size() == 0) flag("pop1_from_empty");
        else fly1.push_back(exp1.pop_front());
      end
      rn1_prev   = rnext1;
      hold1_prev = m_valid1 & ~m_ready1;
      data1_prev = m_data1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic write0(input logic [DW-1:0] d);
    int guard = 0;
    while (3'(wptr0 - rptr0) == 3'd4) begin
      step();
      guard++;
      if (guard > 200) begin
        flag("write0_fifo_stuck_full");
        return;
      end
    end
    wr_en0 = 1'b1; wr_data0 = d;
    step();
    wr_en0 = 1'b0;
  endtask

  task automatic write1(input logic [DW-1:0] d);
    wr_en1 = 1'b1; wr_data1 = d;
    step();
    wr_en1 = 1'b0;
  endtask

  initial begin
    int base;
    int guard;
    repeat (3) step();
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    check("rst_m_valid", {31'b0, m_valid0}, 32'd0);
    check("rst_occ", {30'b0, occ0}, 32'd0);
    check("rst_pop_cnt", {16'b0, pop_cnt0}, 32'd0);
    check("rst_m_data", m_data0, 32'd0);
    step();

    // RDLAT=0 full throughput
    write0(32'h11); write0(32'h22); write0(32'h33); write0(32'h44);
    step(); step();
    en0 = 1'b1; m_ready0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_rnext", {31'b0, rnext0}, (k < 4) ? 32'd1 : 32'd0);
      check("t1_m_valid", {31'b0, m_valid0}, (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
    end
    check("t1_pop_cnt", {16'b0, pop_cnt0}, 32'd4);
    step();

    // RDLAT=1 paced pops
    write1(32'h11); write1(32'h22); write1(32'h33); write1(32'h44);
    step(); step();
    en1 = 1'b1; m_ready1 = 1'b1;
    repeat (12) step();
    check("t2_rnext_cnt", rn_cnt1, 32'd4);
    check("t2_pop_cnt", {16'b0, pop_cnt1}, 32'd4);
    check("t2_occ", {30'b0, occ1}, 32'd0);

    // backpressure
    m_ready0 = 1'b0;
    base = rn_cnt0;
    write0(32'h11); write0(32'h22); write0(32'h33); write0(32'h44);
    repeat (6) step();
    check("t3_pops", rn_cnt0 - base, 32'd2);
    check("t3_occ", {30'b0, occ0}, 32'd2);
    check("t3_m_data", m_data0, 32'h11);
    m_ready0 = 1'b1;
    repeat (10) step();
    check("t3_pop_cnt", {16'b0, pop_cnt0}, 32'd8);
    check("t3_occ_drained", {30'b0, occ0}, 32'd0);

    // en low drains the buffer without popping
    m_ready0 = 1'b0;
    write0(32'h55); write0(32'h66); write0(32'h77);
    repeat (5) step();
    check("t4_occ_full", {30'b0, occ0}, 32'd2);
    en0 = 1'b0; m_ready0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t4_rnext_off", {31'b0, rnext0}, 32'd0);
    end
    check("t4_occ_empty", {30'b0, occ0}, 32'd0);
    step();
    en0 = 1'b1;
    @(negedge clk);
    check("t4_resume_rnext", {31'b0, rnext0}, 32'd1);
    @(negedge clk);
    check("t4_resume_valid", {31'b0, m_valid0}, 32'd1);
    repeat (3) step();
    check("t4_pop_cnt", {16'b0, pop_cnt0}, 32'd11);

    // reset while full
    m_ready0 = 1'b0;
    write0(32'h88); write0(32'h99); write0(32'hAA); write0(32'hBB);
    repeat (6) step();
    check("t5_occ_before", {30'b0, occ0}, 32'd2);
    rst0 = 1'b0;
    @(negedge clk);
    step();
    rst0 = 1'b1;
    @(negedge clk);
    check("t5_m_valid", {31'b0, m_valid0}, 32'd0);
    check("t5_occ", {30'b0, occ0}, 32'd0);
    check("t5_pop_cnt", {16'b0, pop_cnt0}, 32'd0);
    step();
    m_ready0 = 1'b1;
    repeat (6) step();
    check("t5_pop_cnt_after", {16'b0, pop_cnt0}, 32'd2);

    // counter wrap after 65537 handshakes
    rst0 = 1'b0;
    step();
    rst0 = 1'b1;
    for (int i = 1; i <= 65537; i++) write0(i);
    guard = 0;
    while (!(occ0 == 2'd0 && rqempty0) && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) flag("t6_drain_timeout");
    step();
    check("t6_pop_cnt_wrap", {16'b0, pop_cnt0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
